// File: rtl/uitpg_multi.sv
// ============================================================================
// Module   : uitpg_multi
// Purpose  : Parametrised video test-pattern generator, 2-cycle sync-aligned.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uitpg_multi #(
    parameter int DATA_W      = 8,
    parameter int H_ACT       = 1920,
    parameter int CNT_W       = 12,
    parameter int GRID_LOG2   = 4,
    parameter int AUTO_FRAMES = 64
) (
    input  logic                  tpg_clk_i,
    input  logic                  tpg_rstn_i,
    input  logic                  tpg_vs_i,
    input  logic                  tpg_hs_i,
    input  logic                  tpg_de_i,
    input  logic [3:0]            tpg_mode_i,
    input  logic                  tpg_auto_i,
    output logic                  tpg_vs_o,
    output logic                  tpg_hs_o,
    output logic                  tpg_de_o,
    output logic [3*DATA_W-1:0]   tpg_data_o,
    output logic [3:0]            tpg_mode_o
);

    localparam int                  c_BAR_W     = H_ACT / 8;
    localparam int                  c_AUTO_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [CNT_W-1:0]    c_BAR_LAST  = CNT_W'(c_BAR_W - 1);
    localparam logic [c_AUTO_W-1:0] c_AUTO_LAST = c_AUTO_W'(AUTO_FRAMES - 1);
    localparam logic [DATA_W-1:0]   c_F         = '1;
    localparam logic [DATA_W-1:0]   c_Z         = '0;
    localparam logic [3:0]          c_LAST_MODE = 4'd9;

    // ------------------------------------------------------------------
    // Reset bridge: asynchronous assert, synchronous release
    // ------------------------------------------------------------------
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rstn;

    always_ff @(posedge tpg_clk_i or negedge tpg_rstn_i) begin
        if (!tpg_rstn_i) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rstn = r_rst_sync;

    // ------------------------------------------------------------------
    // Stage 1: registered syncs and counters for the current input pixel
    // ------------------------------------------------------------------
    logic                r_vs1;
    logic                r_hs1;
    logic                r_de1;
    logic [CNT_W-1:0]    r_h;
    logic [CNT_W-1:0]    r_v;
    logic [CNT_W-1:0]    r_bar_px;
    logic [2:0]          r_bar_idx;
    logic [7:0]          r_frm;
    logic [3:0]          r_mode;
    logic [c_AUTO_W-1:0] r_acnt;

    logic                w_fs;
    logic                w_de_fall;
    logic [3:0]          w_mode_nxt;
    logic [c_AUTO_W-1:0] w_acnt_nxt;

    assign w_fs      = tpg_vs_i & ~r_vs1;
    assign w_de_fall = r_de1 & ~tpg_de_i;

    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_vs1 <= 1'b0;
            r_hs1 <= 1'b0;
            r_de1 <= 1'b0;
        end else begin
            r_vs1 <= tpg_vs_i;
            r_hs1 <= tpg_hs_i;
            r_de1 <= tpg_de_i;
        end
    end

    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_h <= '0;
        end else if (!tpg_de_i || !r_de1) begin
            r_h <= '0;
        end else begin
            r_h <= r_h + CNT_W'(1);
        end
    end

    // A frame start takes priority over a coincident end-of-line
    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_v <= '0;
        end else if (w_fs) begin
            r_v <= '0;
        end else if (w_de_fall) begin
            r_v <= r_v + CNT_W'(1);
        end
    end

    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
        end else if (!tpg_de_i || !r_de1) begin
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
        end else if (r_bar_px == c_BAR_LAST) begin
            r_bar_px <= '0;
            if (r_bar_idx != 3'd7) begin
                r_bar_idx <= r_bar_idx + 3'd1;
            end
        end else begin
            r_bar_px <= r_bar_px + CNT_W'(1);
        end
    end

    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_frm <= 8'd0;
        end else if (w_fs) begin
            r_frm <= r_frm + 8'd1;
        end
    end

    // Mode only moves at frame start; the auto counter idles at 0 in manual mode
    always_comb begin
        w_mode_nxt = r_mode;
        w_acnt_nxt = r_acnt;
        if (!tpg_auto_i) begin
            w_acnt_nxt = '0;
        end
        if (w_fs) begin
            if (tpg_auto_i) begin
                if (r_acnt == c_AUTO_LAST) begin
                    w_acnt_nxt = '0;
                    w_mode_nxt = (r_mode >= c_LAST_MODE) ? 4'd0 : r_mode + 4'd1;
                end else begin
                    w_acnt_nxt = r_acnt + c_AUTO_W'(1);
                end
            end else begin
                w_mode_nxt = tpg_mode_i;
            end
        end
    end

    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_mode <= 4'd0;
            r_acnt <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_acnt <= w_acnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pattern selection from stage-1 state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    w_scroll;
    logic [DATA_W-1:0]   w_lh;
    logic [DATA_W-1:0]   w_lv;
    logic [DATA_W-1:0]   w_ls;
    logic                w_chk;
    logic [3*DATA_W-1:0] w_pix;

    assign w_scroll = r_h + CNT_W'({r_frm, 2'b00});
    assign w_lh     = DATA_W'(r_h);
    assign w_lv     = DATA_W'(r_v);
    assign w_ls     = DATA_W'(w_scroll);
    assign w_chk    = r_h[GRID_LOG2] ^ r_v[GRID_LOG2];

    always_comb begin
        w_pix = '0;
        case (r_mode)
            4'd1: w_pix = {c_F, c_F, c_F};
            4'd2: w_pix = {c_F, c_Z, c_Z};
            4'd3: w_pix = {c_Z, c_F, c_Z};
            4'd4: w_pix = {c_Z, c_Z, c_F};
            4'd5: w_pix = w_chk ? {c_Z, c_Z, c_Z} : {c_F, c_F, c_F};
            4'd6: w_pix = {w_lh, w_lh, w_lh};
            4'd7: w_pix = {w_lv, w_lv, w_lv};
            4'd8: begin
                case (r_bar_idx)
                    3'd0:    w_pix = {c_F, c_F, c_F};
                    3'd1:    w_pix = {c_F, c_F, c_Z};
                    3'd2:    w_pix = {c_Z, c_F, c_F};
                    3'd3:    w_pix = {c_Z, c_F, c_Z};
                    3'd4:    w_pix = {c_F, c_Z, c_F};
                    3'd5:    w_pix = {c_F, c_Z, c_Z};
                    3'd6:    w_pix = {c_Z, c_Z, c_F};
                    default: w_pix = {c_Z, c_Z, c_Z};
                endcase
            end
            4'd9:    w_pix = {w_ls, w_ls, w_ls};
            default: w_pix = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    logic                r_vs2;
    logic                r_hs2;
    logic                r_de2;
    logic [3*DATA_W-1:0] r_data;

    always_ff @(posedge tpg_clk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_vs2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_de2  <= 1'b0;
            r_data <= '0;
        end else begin
            r_vs2  <= r_vs1;
            r_hs2  <= r_hs1;
            r_de2  <= r_de1;
            r_data <= r_de1 ? w_pix : '0;
        end
    end

    assign tpg_vs_o   = r_vs2;
    assign tpg_hs_o   = r_hs2;
    assign tpg_de_o   = r_de2;
    assign tpg_data_o = r_data;
    assign tpg_mode_o = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_uitpg_multi.sv
// ============================================================================
// Module   : tb_uitpg_multi
// Purpose  : Randomised frame stimulus against a pixel-coordinate reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uitpg_multi;

    localparam int DW = 8;
    localparam int HA = 64;
    localparam int CW = 12;
    localparam int GL = 2;
    localparam int AF = 2;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b1;
    logic          vs     = 1'b0;
    logic          hs     = 1'b0;
    logic          de     = 1'b0;
    logic          auto_i = 1'b0;
    logic [3:0]    mode_i = 4'd0;
    logic          vs_o;
    logic          hs_o;
    logic          de_o;
    logic [3*DW-1:0] data_o;
    logic [3:0]    mode_o;

    uitpg_multi #(
        .DATA_W(DW), .H_ACT(HA), .CNT_W(CW), .GRID_LOG2(GL), .AUTO_FRAMES(AF)
    ) dut (
        .tpg_clk_i (clk),
        .tpg_rstn_i(rstn),
        .tpg_vs_i  (vs),
        .tpg_hs_i  (hs),
        .tpg_de_i  (de),
        .tpg_mode_i(mode_i),
        .tpg_auto_i(auto_i),
        .tpg_vs_o  (vs_o),
        .tpg_hs_o  (hs_o),
        .tpg_de_o  (de_o),
        .tpg_data_o(data_o),
        .tpg_mode_o(mode_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int cyc; logic [26:0] v; } pitem_t;
    typedef struct { int cyc; logic [3:0]  m; } mitem_t;
    pitem_t sq[$];
    mitem_t mq[$];

    // Reference state: applied mode, frames since reset, auto frame count
    int m_mode = 0;
    int m_frm  = 0;
    int m_acnt = 0;
    bit m_pvs  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int m, input int x, input int y, input int f);
        logic [7:0] g;
        int b;
        case (m)
            1: return 24'hFFFFFF;
            2: return 24'hFF0000;
            3: return 24'h00FF00;
            4: return 24'h0000FF;
            5: return ((((x >> GL) ^ (y >> GL)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
            6: begin g = 8'(x % 256); return {g, g, g}; end
            7: begin g = 8'(y % 256); return {g, g, g}; end
            8: begin
                b = x / (HA / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            9: begin g = 8'(((x + 4 * f) % 4096) % 256); return {g, g, g}; end
            default: return 24'h000000;
        endcase
    endfunction

    // Monitor: outputs lag the driven pixel by 2 cycles, the mode by 1
    always @(negedge clk) begin
        pitem_t it;
        mitem_t mt;
        while (sq.size() > 0 && sq[0].cyc + 2 <= cyc) begin
            it = sq.pop_front();
            if (it.cyc + 2 == cyc) check("pix", {5'd0, vs_o, hs_o, de_o, data_o}, {5'd0, it.v});
            else                   check("pix_lost", 32'd0, 32'd1);
        end
        while (mq.size() > 0 && mq[0].cyc + 1 <= cyc) begin
            mt = mq.pop_front();
            if (mt.cyc + 1 == cyc) check("mode", {28'd0, mode_o}, {28'd0, mt.m});
            else                   check("mode_lost", 32'd0, 32'd1);
        end
    end

    task automatic drive(input bit v, input bit h, input bit d, input int x, input int y);
        pitem_t it;
        mitem_t mt;
        logic [23:0] px;
        @(negedge clk);
        vs = v; hs = h; de = d;
        if (v && !m_pvs) begin
            m_frm = (m_frm + 1) % 256;
            if (auto_i) begin
                m_acnt++;
                if (m_acnt == AF) begin
                    m_acnt = 0;
                    m_mode = (m_mode >= 9) ? 0 : m_mode + 1;
                end
            end else begin
                m_mode = int'(mode_i);
            end
        end
        m_pvs = v;
        if (!auto_i) m_acnt = 0;
        px = d ? pat(m_mode, x, y, m_frm) : 24'h0;
        it.cyc = cyc; it.v = {v, h, d, px};
        sq.push_back(it);
        mt.cyc = cyc; mt.m = 4'(m_mode);
        mq.push_back(mt);
    endtask

    task automatic line(input int y, input int npx);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 1'b0, 0, 0);
        for (int x = 0; x < npx; x++) drive(1'b0, 1'b0, 1'b1, x, y);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic frame(input bit with_vs, input int nl, input int npx, input bit chg);
        if (with_vs) begin
            drive(1'b1, 1'b0, 1'b0, 0, 0);
            drive(1'b1, 1'b1, 1'b0, 0, 0);
            drive(1'b0, 1'b0, 1'b0, 0, 0);
        end
        for (int y = 0; y < nl; y++) begin
            if (chg && y == nl / 2) mode_i = 4'($urandom_range(0, 15));
            line(y, npx);
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vs"},   {31'd0, vs_o},   32'd0);
        check({tag, "_hs"},   {31'd0, hs_o},   32'd0);
        check({tag, "_de"},   {31'd0, de_o},   32'd0);
        check({tag, "_data"}, {8'd0, data_o},  32'd0);
        check({tag, "_mode"}, {28'd0, mode_o}, 32'd0);
    endtask

    initial begin
        int t;
        // Power-on reset
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        mode_i = 4'd2;
        rstn   = 1'b1;
        repeat (4) @(negedge clk);

        // Partial frame is black, then red frames
        frame(1'b0, 8, HA, 1'b0);
        frame(1'b1, 8, HA, 1'b0);
        frame(1'b1, 8, HA, 1'b0);
        // Colour bars with an overlong line
        mode_i = 4'd8; frame(1'b1, 8, HA + 1, 1'b0);
        mode_i = 4'd5; frame(1'b1, 8, HA, 1'b0);
        mode_i = 4'd6; frame(1'b1, 4, HA, 1'b0);
        mode_i = 4'd7; frame(1'b1, 8, HA, 1'b0);
        // Scrolling ramp, with a mid-frame mode request that must not apply yet
        mode_i = 4'd9; frame(1'b1, 8, HA, 1'b1);
        mode_i = 4'd9; frame(1'b1, 3, HA, 1'b0);
        frame(1'b1, 3, HA, 1'b0);
        // Random manual modes, including the black 10..15 range
        for (int i = 0; i < 8; i++) begin
            mode_i = 4'($urandom_range(0, 15));
            frame(1'b1, 4, HA + int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // Auto-cycle: requested mode is ignored
        auto_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            mode_i = 4'($urandom_range(0, 15));
            frame(1'b1, 2, HA, 1'b0);
        end
        auto_i = 1'b0;
        mode_i = 4'd9;
        frame(1'b1, 2, HA, 1'b0);

        // Reset pulse in the middle of an active line
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        for (int x = 0; x < 20; x++) drive(1'b0, 1'b0, 1'b1, x, 0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero("arst");
        sq.delete();
        mq.delete();
        m_mode = 0; m_frm = 0; m_acnt = 0; m_pvs = 1'b0;
        vs = 1'b0; hs = 1'b0; de = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_mode", {28'd0, mode_o}, 32'd0);
        frame(1'b0, 2, HA, 1'b0);
        frame(1'b1, 3, HA, 1'b0);
        frame(1'b1, 2, HA, 1'b0);
        frame(1'b1, 2, HA, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 0);

        t = 0;
        while ((sq.size() > 0 || mq.size() > 0) && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (sq.size() > 0 || mq.size() > 0) check("drain_timeout", 32'd1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
